// File: rtl/ysyx_23060337_ifu_sram_if.sv
// Fetch read channel between the IFU (master) and the instruction SRAM (slave):
// AR carries the byte address, R returns the word plus a 2-bit status.
interface ysyx_23060337_ifu_sram_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;

   modport master (
      output arvalid, araddr, rready,
      input  arready, rvalid, rdata, rresp
   );

   modport slave (
      input  arvalid, araddr, rready,
      output arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/ysyx_23060337_ifu_sram.sv
// Instruction SRAM responder: one outstanding fetch, fixed LATENCY, registered
// response with misaligned / out-of-range reporting and a side load port.
module ysyx_23060337_ifu_sram #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
   parameter int unsigned       LATENCY   = 1,
   localparam int unsigned      IdxW      = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   ysyx_23060337_ifu_sram_if.slave bus,
   input  logic                    ld_en,
   input  logic [IdxW-1:0]         ld_addr,
   input  logic [DATA_W-1:0]       ld_data
);

   localparam logic [ADDR_W:0] SpanBytes = (ADDR_W+1)'(DEPTH * 4);
   localparam logic [3:0]      CntInit   = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              capture;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] offset;
   logic [IdxW-1:0]   rd_idx;
   logic              misaligned;
   logic              out_of_range;

   assign accept = (state_q == StIdle) && rst && bus.arvalid;

   // With LATENCY==1 the capture edge is the acceptance edge, so use the live address.
   assign rd_addr      = (state_q == StIdle) ? bus.araddr : addr_q;
   assign offset       = rd_addr - BASE_ADDR;
   assign rd_idx       = offset[IdxW+1:2];
   assign misaligned   = rd_addr[1:0] != 2'b00;
   assign out_of_range = {1'b0, offset} >= SpanBytes;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         rresp_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
      end
   end

   // Array is never reset and stays writable while rst is asserted.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d = bus.araddr;
               cnt_d  = CntInit;
               if (LATENCY == 1) begin
                  state_d = StResp;
                  capture = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
               capture = 1'b1;
            end
         end
         StResp: begin
            if (bus.rready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Capture reads the pre-edge array, so a same-edge load returns the old word.
   always_comb begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      if (capture) begin
         if (misaligned) begin
            rdata_d = '0;
            rresp_d = 2'b11;
         end else if (out_of_range) begin
            rdata_d = '0;
            rresp_d = 2'b10;
         end else begin
            rdata_d = mem[rd_idx];
            rresp_d = 2'b00;
         end
      end
   end

   always_comb begin
      bus.arready = (state_q == StIdle) && rst;
      bus.rvalid  = state_q == StResp;
      bus.rdata   = rdata_q;
      bus.rresp   = rresp_q;
   end

endmodule

// File: tb/tb_ysyx_23060337_ifu_sram.sv
// Bench for the instruction SRAM: three instances at LATENCY 1, 3 and 4, checked
// against a word-array reference model plus hand sequences for collisions and reset.
module tb_ysyx_23060337_ifu_sram;

   localparam int unsigned NDUT  = 3;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        arvalid [NDUT];
   logic [31:0] araddr  [NDUT];
   logic        rready  [NDUT];
   logic        ld_en   [NDUT];
   logic [9:0]  ld_addr [NDUT];
   logic [31:0] ld_data [NDUT];
   logic        arready [NDUT];
   logic        rvalid  [NDUT];
   logic [31:0] rdata   [NDUT];
   logic [1:0]  rresp   [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ysyx_23060337_ifu_sram_if #(.ADDR_W(32), .DATA_W(32)) bus ();
      assign bus.arvalid = arvalid[g];
      assign bus.araddr  = araddr[g];
      assign bus.rready  = rready[g];
      assign arready[g]  = bus.arready;
      assign rvalid[g]   = bus.rvalid;
      assign rdata[g]    = bus.rdata;
      assign rresp[g]    = bus.rresp;
      ysyx_23060337_ifu_sram #(
         .ADDR_W   (32),
         .DATA_W   (32),
         .DEPTH    (DEPTH),
         .BASE_ADDR(BASE),
         .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clk    (clk),
         .rst    (rst),
         .bus    (bus),
         .ld_en  (ld_en[g]),
         .ld_addr(ld_addr[g]),
         .ld_data(ld_data[g])
      );
   end

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] model [NDUT][DEPTH];

   typedef struct {
      int          dut;
      logic [31:0] addr;
      int          hold;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs [9];

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
   endfunction

   function automatic logic [1:0] ref_resp(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if ((a % 4) != 0) return 2'b11;
      if (off >= 32'(DEPTH * 4)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] ref_data(input int d, input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (ref_resp(a) != 2'b00) return 32'h0;
      return model[d][off / 4];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int d, input int idx, input logic [31:0] w);
      ld_en[d]   = 1'b1;
      ld_addr[d] = 10'(idx);
      ld_data[d] = w;
      tick();
      ld_en[d]     = 1'b0;
      model[d][idx] = w;
   endtask

   task automatic fetch(input int d, input logic [31:0] addr, input int hold,
                        input logic [31:0] exp_d, input logic [1:0] exp_r, input string tag);
      int waited;
      check({tag, ".arready"}, 64'(arready[d]), 64'd1);
      arvalid[d] = 1'b1;
      araddr[d]  = addr;
      rready[d]  = 1'b0;
      tick();
      arvalid[d] = 1'b0;
      araddr[d]  = $urandom();
      waited = 1;
      while (!rvalid[d] && waited < 40) begin
         rready[d] = 1'($urandom_range(0, 1));
         tick();
         waited++;
      end
      rready[d] = 1'b0;
      check({tag, ".latency"}, 64'(waited), 64'(lat_of(d)));
      check({tag, ".resp"}, 64'({rvalid[d], arready[d], rresp[d], rdata[d]}),
            64'({1'b1, 1'b0, exp_r, exp_d}));
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, ".hold"}, 64'({rvalid[d], arready[d], rresp[d], rdata[d]}),
               64'({1'b1, 1'b0, exp_r, exp_d}));
      end
      rready[d] = 1'b1;
      tick();
      rready[d] = 1'b0;
      check({tag, ".done"}, 64'({rvalid[d], arready[d]}), 64'(2'b01));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          d;
      int          idx;
      logic [31:0] a;
      logic [31:0] w;
      logic        seen;

      rst = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         arvalid[i] = 1'b1;
         araddr[i]  = BASE;
         rready[i]  = 1'b0;
         ld_en[i]   = 1'b0;
         ld_addr[i] = '0;
         ld_data[i] = '0;
      end
      repeat (3) begin
         tick();
         for (int i = 0; i < NDUT; i++)
            check("reset", 64'({arready[i], rvalid[i], rdata[i], rresp[i]}), 64'd0);
      end
      for (int i = 0; i < NDUT; i++) arvalid[i] = 1'b0;

      // Program image is loaded while reset is still asserted.
      for (int k = 0; k < DEPTH; k++) begin
         for (int i = 0; i < NDUT; i++) begin
            case (k)
               0:       w = 32'h0000_0413;
               1:       w = 32'h0010_0093;
               2:       w = 32'h1234_5678;
               1023:    w = 32'hDEAD_BEEF;
               default: w = $urandom();
            endcase
            ld_en[i]    = 1'b1;
            ld_addr[i]  = 10'(k);
            ld_data[i]  = w;
            model[i][k] = w;
         end
         tick();
      end
      for (int i = 0; i < NDUT; i++) ld_en[i] = 1'b0;
      check("reset.hold", 64'({arready[0], rvalid[1], rdata[2], rresp[0]}), 64'd0);

      rst = 1'b1;
      #1;
      for (int i = 0; i < NDUT; i++) check("release.arready", 64'(arready[i]), 64'd1);

      vecs[0] = '{0, 32'h8000_0000, 0, 32'h0000_0413, 2'b00};
      vecs[1] = '{0, 32'h8000_0004, 0, 32'h0010_0093, 2'b00};
      vecs[2] = '{1, 32'h8000_0008, 4, 32'h1234_5678, 2'b00};
      vecs[3] = '{0, 32'h8000_0002, 0, 32'h0000_0000, 2'b11};
      vecs[4] = '{0, 32'h8000_1000, 0, 32'h0000_0000, 2'b10};
      vecs[5] = '{0, 32'h7FFF_FFFC, 0, 32'h0000_0000, 2'b10};
      vecs[6] = '{0, 32'h8000_0FFC, 0, 32'hDEAD_BEEF, 2'b00};
      vecs[7] = '{2, 32'h8000_1003, 1, 32'h0000_0000, 2'b11};
      vecs[8] = '{2, 32'h8000_0FFC, 2, 32'hDEAD_BEEF, 2'b00};
      for (int v = 0; v < 9; v++)
         fetch(vecs[v].dut, vecs[v].addr, vecs[v].hold, vecs[v].exp_data, vecs[v].exp_resp,
               $sformatf("vec%0d", v));

      // Load and capture of word 2 on the same edge: old word comes back.
      arvalid[0] = 1'b1;
      araddr[0]  = BASE + 32'd8;
      ld_en[0]   = 1'b1;
      ld_addr[0] = 10'd2;
      ld_data[0] = 32'hCAFE_0002;
      tick();
      arvalid[0]  = 1'b0;
      ld_en[0]    = 1'b0;
      model[0][2] = 32'hCAFE_0002;
      check("col.old", 64'({rvalid[0], rresp[0], rdata[0]}), 64'({1'b1, 2'b00, 32'h1234_5678}));
      rready[0] = 1'b1;
      tick();
      rready[0] = 1'b0;
      fetch(0, BASE + 32'd8, 0, 32'hCAFE_0002, 2'b00, "col.new");

      // LATENCY=4: load at the second WAIT edge lands before capture.
      arvalid[2] = 1'b1;
      araddr[2]  = BASE + 32'd20;
      tick();
      arvalid[2] = 1'b0;
      tick();
      check("l4.wait1", 64'(rvalid[2]), 64'd0);
      load(2, 5, 32'hBEEF_0005);
      check("l4.wait2", 64'(rvalid[2]), 64'd0);
      tick();
      check("l4.new", 64'({rvalid[2], rresp[2], rdata[2]}), 64'({1'b1, 2'b00, 32'hBEEF_0005}));
      rready[2] = 1'b1;
      tick();
      rready[2] = 1'b0;

      // Reset one edge after acceptance drops the request for good.
      arvalid[1] = 1'b1;
      araddr[1]  = BASE + 32'd12;
      tick();
      arvalid[1] = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check("mid.arready", 64'(arready[1]), 64'd0);
      tick();
      check("mid.rvalid", 64'(rvalid[1]), 64'd0);
      rst = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (rvalid[1]) seen = 1'b1;
      end
      check("mid.dropped", 64'(seen), 64'd0);
      fetch(1, BASE + 32'd12, 0, model[1][3], 2'b00, "mid.after");

      for (int n = 0; n < 150; n++) begin
         d = $urandom_range(0, NDUT - 1);
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, DEPTH - 1);
            w   = $urandom();
            load(d, idx, w);
         end
         case ($urandom_range(0, 4))
            0, 1:    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            2:       a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            3:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
            default: a = $urandom();
         endcase
         fetch(d, a, $urandom_range(0, 2), ref_data(d, a), ref_resp(a), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ysyx_23060337_ifu_sram.md
Name: ysyx_23060337_ifu_sram

Overview:
Instruction-memory responder that serves fetch requests from the IFU over a valid/ready read channel (AR request, R response). It holds a word-addressed SRAM array mapped at BASE_ADDR and returns data after a programmable fixed latency. It reports an error for out-of-range or misaligned requests. A side load port lets the bench or boot logic write program images.

Parameters:
ADDR_W, 32, request address width in bits
DATA_W, 32, word width in bits
DEPTH, 1024, number of words in the array
BASE_ADDR, 32'h80000000, byte address of word 0
LATENCY, 1, cycles from request acceptance to rvalid; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
arvalid  input  1  fetch request valid
arready  output  1  responder can accept a request
araddr  input  ADDR_W  fetch byte address
rvalid  output  1  response valid
rready  input  1  IFU accepts response
rdata  output  DATA_W  fetched word
rresp  output  2  2'b00 OKAY, 2'b10 SLVERR (out of range), 2'b11 MISALIGNED
ld_en  input  1  load-port write enable
ld_addr  input  clog2(DEPTH)  load-port word index
ld_data  input  DATA_W  load-port write data

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE, counter=0, rvalid=0, rdata=0, rresp=0.
  - arready is forced to 0 while rst==0.
  - Array contents are not cleared.
- arready = (state==IDLE) && rst, combinational. The responder holds at most one request outstanding.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on arvalid&&arready at an edge, latch araddr and set counter=LATENCY-1.
    - If LATENCY==1, go directly to RESP at that edge.
    - Otherwise go to WAIT.
  - WAIT: counter decrements by 1 each edge. When counter==1 at an edge, go to RESP. The WAIT-to-RESP transition happens exactly LATENCY edges after acceptance.
  - RESP: rvalid=1. rdata and rresp are stable until the handshake. On rvalid&&rready, return to IDLE and clear rvalid at that edge. No back-to-back acceptance in the same cycle; the next request is accepted at the earliest one cycle later.
- Address check, evaluated on the latched address:
  - offset = addr - BASE_ADDR, computed ADDR_W bits with wrap-around.
  - Misaligned: addr[1:0]!=0 gives rresp=2'b11, rdata=0. Misaligned takes priority over range.
  - Out of range: offset >= DEPTH*4 (which includes addr < BASE_ADDR via wrap) gives rresp=2'b10, rdata=0.
  - Otherwise rresp=0 and rdata=mem[offset>>2].
- rdata and rresp are registered, captured at the edge entering RESP.
- Load port: on ld_en at an edge, mem[ld_addr] <= ld_data. This is accepted in any state, including during reset.
- Simultaneous load and read capture of the same word at one edge: rdata gets the OLD contents. A load during WAIT to the pending word before the capture edge is visible in rdata.
- Reset mid-transaction: the request is dropped and rvalid falls at that edge. No response is ever produced for it.
- araddr changes while not accepted are ignored. araddr is sampled only at the acceptance edge.
- rready while rvalid==0 is ignored.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with arvalid=1 -> arready=0, rvalid=0, rdata=0, rresp=0 throughout; arready=1 the cycle after rst=1.
2. Basic fetch, LATENCY=1: load mem[0]=32'h00000413, mem[1]=32'h00100093. Request 0x80000000, then 0x80000004, with rready=1 -> rvalid the cycle after each acceptance, with rdata 0x00000413 then 0x00100093 and rresp=0. arready low while busy.
3. Latency and backpressure, LATENCY=3: request 0x80000008 -> rvalid rises exactly 3 edges after acceptance. Hold rready=0 for 4 cycles -> rvalid/rdata stable, arready=0. Raise rready -> back to IDLE next edge.
4. Errors:
   - 0x80000002 -> rresp=2'b11, rdata=0.
   - 0x80001000 with DEPTH=1024 -> rresp=2'b10, rdata=0.
   - 0x7FFFFFFC -> rresp=2'b10.
   - 0x80000FFC -> rresp=0, rdata=mem[1023].
5. Load collisions:
   - LATENCY=1, ld_en to word 2 at the same edge as the capture for 0x80000008 -> old data returned; a re-fetch returns the new data.
   - LATENCY=4, load at the 2nd WAIT edge -> new data returned.
6. Reset mid-operation: accept a request with LATENCY=3, assert rst=0 after 1 edge -> no rvalid ever for it. After release, a new request completes normally.
